// File: rtl/rename_map.sv
// rename_map -- register rename map table for an N-wide rename stage.
//
// Every cycle up to N instructions are renamed together. Each lane that writes
// a non-zero architectural register takes one physical tag from the freelist.
// Lanes are accepted as an in-order prefix and stop at the first valid lane
// that cannot get a tag. Sources and stale tags are read from the speculative
// map. A source or stale tag is overridden by the new tag of the youngest
// accepted lower lane that writes the same architectural register.
// Architectural register 0 is never remapped.
//
// Optional feature macro: RENAME_RECOVER_EN
//   When defined, the block also keeps a committed map table. Retire writes go
//   into it. A flush copies it, together with that cycle's retire writes, into
//   the speculative table.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   flush, ret_en,          (RENAME_RECOVER_EN only) recovery request and
//   ret_arch, ret_tag       retire-lane writes to the committed table
//   rn_valid, rn_dest_wr    per-lane instruction valid / writes a destination
//   rn_dest, rn_src1/2      per-lane architectural register indices
//   rn_stall                downstream full: rename nothing this cycle
//   free_reg, _valid        compacted freelist tags and their grant mask
//   dispatch_en             compacted tag request to the freelist
//   rn_accept               per-lane renamed-this-cycle flag
//   src1/src2/dest/stale_tag  per-lane renamed tags, all zero when not accepted

`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

module rename_map #(
    parameter int N          = `N,
    parameter int ARCH_COUNT = 32,
    parameter int PR_COUNT   = `PHYS_REG_SZ_R10K,
    localparam int AW        = $clog2(ARCH_COUNT),
    localparam int TW        = $clog2(PR_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset_n,
`ifdef RENAME_RECOVER_EN
    input  logic                  flush,
    input  logic [N-1:0]          ret_en,
    input  logic [N-1:0][AW-1:0]  ret_arch,
    input  logic [N-1:0][TW-1:0]  ret_tag,
`endif
    input  logic [N-1:0]          rn_valid,
    input  logic [N-1:0]          rn_dest_wr,
    input  logic [N-1:0][AW-1:0]  rn_dest,
    input  logic [N-1:0][AW-1:0]  rn_src1,
    input  logic [N-1:0][AW-1:0]  rn_src2,
    input  logic                  rn_stall,
    input  logic [N-1:0][TW-1:0]  free_reg,
    input  logic [N-1:0]          free_reg_valid,
    output logic [N-1:0]          dispatch_en,
    output logic [N-1:0]          rn_accept,
    output logic [N-1:0][TW-1:0]  src1_tag,
    output logic [N-1:0][TW-1:0]  src2_tag,
    output logic [N-1:0][TW-1:0]  dest_tag,
    output logic [N-1:0][TW-1:0]  stale_tag
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    logic [TW-1:0] spec_q [ARCH_COUNT];
    logic [TW-1:0] spec_d [ARCH_COUNT];

    logic          flush_w;
    logic [N-1:0]  need_tag;   // lane consumes a freelist tag
    logic [N-1:0]  acc;
    logic [KW-1:0] kidx [N];   // position of the lane among requesting lanes
    int            nreq;

`ifdef RENAME_RECOVER_EN
    logic [TW-1:0] commit_q [ARCH_COUNT];
    logic [TW-1:0] commit_d [ARCH_COUNT];
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Lane control. Requests count every eligible lane, whether or not it is
    // accepted. Acceptance stops at the first valid lane that fails. Invalid
    // lanes below a lane do not block it.
    always_comb begin
        logic active;
        logic ok;
        logic grant;
        active   = reset_n && !rn_stall && !flush_w;
        ok       = 1'b1;
        nreq     = 0;
        need_tag = '0;
        acc      = '0;
        for (int i = 0; i < N; i++) begin
            kidx[i]     = KW'(nreq);
            need_tag[i] = active && rn_valid[i] && rn_dest_wr[i] && (rn_dest[i] != '0);
            grant       = need_tag[i] ? free_reg_valid[kidx[i]] : 1'b1;
            acc[i]      = active && rn_valid[i] && ok && grant;
            if (rn_valid[i] && !acc[i])
                ok = 1'b0;
            if (need_tag[i])
                nreq = nreq + 1;
        end
        for (int k = 0; k < N; k++)
            dispatch_en[k] = (k < nreq);
    end

    assign rn_accept = acc;

    // Tag outputs with intra-group forwarding. The lanes are scanned in
    // ascending order, so the youngest lower writer has the last word.
    always_comb begin
        logic [TW-1:0] s1;
        logic [TW-1:0] s2;
        logic [TW-1:0] st;
        for (int i = 0; i < N; i++)
            dest_tag[i] = (acc[i] && need_tag[i]) ? free_reg[kidx[i]] : '0;
        for (int i = 0; i < N; i++) begin
            s1 = spec_q[rn_src1[i]];
            s2 = spec_q[rn_src2[i]];
            st = spec_q[rn_dest[i]];
            for (int j = 0; j < i; j++) begin
                if (acc[j] && need_tag[j]) begin
                    if (rn_dest[j] == rn_src1[i]) s1 = dest_tag[j];
                    if (rn_dest[j] == rn_src2[i]) s2 = dest_tag[j];
                    if (rn_dest[j] == rn_dest[i]) st = dest_tag[j];
                end
            end
            src1_tag[i]  = (acc[i] && rn_src1[i] != '0) ? s1 : '0;
            src2_tag[i]  = (acc[i] && rn_src2[i] != '0) ? s2 : '0;
            // A stale tag only has a meaning for lanes that take a new mapping.
            stale_tag[i] = (acc[i] && need_tag[i]) ? st : '0;
        end
    end

    // Next-state tables. The writes are applied in lane order, so the
    // highest-indexed write to an entry wins.
    always_comb begin
`ifdef RENAME_RECOVER_EN
        commit_d = commit_q;
        for (int r = 0; r < N; r++)
            if (ret_en[r] && ret_arch[r] != '0)
                commit_d[ret_arch[r]] = ret_tag[r];
`endif
        spec_d = spec_q;
        for (int i = 0; i < N; i++)
            if (acc[i] && need_tag[i])
                spec_d[rn_dest[i]] = dest_tag[i];
`ifdef RENAME_RECOVER_EN
        if (flush_w)
            spec_d = commit_d;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < ARCH_COUNT; a++)
                spec_q[a] <= TW'(a);
        end else begin
            spec_q <= spec_d;
        end
    end

`ifdef RENAME_RECOVER_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < ARCH_COUNT; a++)
                commit_q[a] <= TW'(a);
        end else begin
            commit_q <= commit_d;
        end
    end
`endif

endmodule

// File: tb/tb_rename_map.sv
// tb_rename_map -- directed self-checking bench for rename_map (N=2, 32 arch
// registers, 64 physical registers). The inputs are driven 1 ns after the
// rising edge. The combinational outputs are checked 1 ns later.
module tb_rename_map;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [1:0]       rn_valid, rn_dest_wr, free_reg_valid;
    logic [1:0][4:0]  rn_dest, rn_src1, rn_src2;
    logic             rn_stall;
    logic [1:0][5:0]  free_reg;
    logic [1:0]       dispatch_en, rn_accept;
    logic [1:0][5:0]  src1_tag, src2_tag, dest_tag, stale_tag;
`ifdef RENAME_RECOVER_EN
    logic             flush;
    logic [1:0]       ret_en;
    logic [1:0][4:0]  ret_arch;
    logic [1:0][5:0]  ret_tag;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    rename_map #(.N(2), .ARCH_COUNT(32), .PR_COUNT(64)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
`ifdef RENAME_RECOVER_EN
        .flush          (flush),
        .ret_en         (ret_en),
        .ret_arch       (ret_arch),
        .ret_tag        (ret_tag),
`endif
        .rn_valid       (rn_valid),
        .rn_dest_wr     (rn_dest_wr),
        .rn_dest        (rn_dest),
        .rn_src1        (rn_src1),
        .rn_src2        (rn_src2),
        .rn_stall       (rn_stall),
        .free_reg       (free_reg),
        .free_reg_valid (free_reg_valid),
        .dispatch_en    (dispatch_en),
        .rn_accept      (rn_accept),
        .src1_tag       (src1_tag),
        .src2_tag       (src2_tag),
        .dest_tag       (dest_tag),
        .stale_tag      (stale_tag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rn_valid = '0; rn_dest_wr = '0; rn_dest = '0; rn_src1 = '0; rn_src2 = '0;
        rn_stall = 1'b0; free_reg = '0; free_reg_valid = '0;
`ifdef RENAME_RECOVER_EN
        flush = 1'b0; ret_en = '0; ret_arch = '0; ret_tag = '0;
`endif
    endtask

    task automatic lane(input int i, input logic v, input logic wr,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        rn_valid[i] = v; rn_dest_wr[i] = wr; rn_dest[i] = d;
        rn_src1[i] = s1; rn_src2[i] = s2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset is asserted while the lanes are valid: nothing may be accepted.
        idle();
        reset_n = 1'b0;
        lane(0, 1, 1, 5, 5, 0); lane(1, 1, 1, 6, 6, 0);
        free_reg[0] = 6'd40; free_reg[1] = 6'd41; free_reg_valid = 2'b11;
        #2;
        $display("[TB] reset with valid lanes");
        check("rst_accept", rn_accept, 2'b00);
        check("rst_dispatch", dispatch_en, 2'b00);
        check("rst_dest0", dest_tag[0], 0);
        tick(); tick();
        reset_n = 1'b1;
        idle();

        // First rename: arch 5 -> 40.
        lane(0, 1, 1, 5, 5, 0);
        free_reg[0] = 6'd40; free_reg[1] = 6'd41; free_reg_valid = 2'b11;
        #1;
        $display("[TB] rename lane0 dest=5 src1=5");
        check("s1_accept", rn_accept, 2'b01);
        check("s1_dispatch", dispatch_en, 2'b01);
        check("s1_dest0", dest_tag[0], 40);
        check("s1_src1_0", src1_tag[0], 5);
        check("s1_stale0", stale_tag[0], 5);
        check("s1_src2_0", src2_tag[0], 0);
        tick(); idle();

        // Read back without writes. Lane 1 has no destination.
        lane(0, 1, 0, 0, 5, 6); lane(1, 1, 0, 0, 7, 0);
        #1;
        $display("[TB] read arch 5,6,7");
        check("s2_accept", rn_accept, 2'b11);
        check("s2_dispatch", dispatch_en, 2'b00);
        check("s2_src1_0", src1_tag[0], 40);
        check("s2_src2_0", src2_tag[0], 6);
        check("s2_src1_1", src1_tag[1], 7);
        check("s2_dest0", dest_tag[0], 0);
        tick(); idle();

        // Intra-group forwarding on arch 3.
        lane(0, 1, 1, 3, 1, 0); lane(1, 1, 1, 3, 3, 0);
        free_reg[0] = 6'd20; free_reg[1] = 6'd21; free_reg_valid = 2'b11;
        #1;
        $display("[TB] lane0 dest=3, lane1 src1=3 dest=3");
        check("s3_accept", rn_accept, 2'b11);
        check("s3_dispatch", dispatch_en, 2'b11);
        check("s3_dest0", dest_tag[0], 20);
        check("s3_dest1", dest_tag[1], 21);
        check("s3_src1_1", src1_tag[1], 20);
        check("s3_stale1", stale_tag[1], 20);
        check("s3_stale0", stale_tag[0], 3);
        check("s3_src1_0", src1_tag[0], 1);
        tick(); idle();

        lane(0, 1, 0, 0, 3, 0); lane(1, 1, 0, 0, 5, 0);
        #1;
        $display("[TB] read arch 3,5");
        check("s4_arch3", src1_tag[0], 21);
        check("s4_arch5", src1_tag[1], 40);
        tick(); idle();

        // Only one tag is granted: lane 1 is rejected and drives zeros.
        lane(0, 1, 1, 8, 0, 0); lane(1, 1, 1, 9, 2, 0);
        free_reg[0] = 6'd30; free_reg[1] = 6'd31; free_reg_valid = 2'b01;
        #1;
        $display("[TB] two requests, one grant");
        check("s5_accept", rn_accept, 2'b01);
        check("s5_dispatch", dispatch_en, 2'b11);
        check("s5_dest0", dest_tag[0], 30);
        check("s5_dest1", dest_tag[1], 0);
        check("s5_src1_1", src1_tag[1], 0);
        check("s5_stale1", stale_tag[1], 0);
        tick(); idle();

        lane(0, 1, 0, 0, 8, 9);
        #1;
        $display("[TB] read arch 8,9");
        check("s6_arch8", src1_tag[0], 30);
        check("s6_arch9", src2_tag[0], 9);
        tick(); idle();

        // A write to arch 0 takes no tag, so lane 1 gets free_reg[0].
        lane(0, 1, 1, 0, 0, 0); lane(1, 1, 1, 7, 0, 0);
        free_reg[0] = 6'd50; free_reg[1] = 6'd51; free_reg_valid = 2'b11;
        #1;
        $display("[TB] lane0 dest=0, lane1 dest=7");
        check("s7_accept", rn_accept, 2'b11);
        check("s7_dispatch", dispatch_en, 2'b01);
        check("s7_dest0", dest_tag[0], 0);
        check("s7_stale0", stale_tag[0], 0);
        check("s7_dest1", dest_tag[1], 50);
        check("s7_stale1", stale_tag[1], 7);
        tick(); idle();

        lane(0, 1, 0, 0, 0, 7);
        #1;
        $display("[TB] read arch 0,7");
        check("s8_arch0", src1_tag[0], 0);
        check("s8_arch7", src2_tag[0], 50);
        tick(); idle();

        // Stall: nothing is renamed and the table is left alone.
        rn_stall = 1'b1;
        lane(0, 1, 1, 10, 0, 0); lane(1, 1, 1, 11, 0, 0);
        free_reg[0] = 6'd55; free_reg[1] = 6'd56; free_reg_valid = 2'b11;
        #1;
        $display("[TB] stall with valid lanes");
        check("s9_accept", rn_accept, 2'b00);
        check("s9_dispatch", dispatch_en, 2'b00);
        check("s9_dest0", dest_tag[0], 0);
        tick(); idle();

        lane(0, 1, 0, 0, 10, 11);
        #1;
        $display("[TB] read arch 10,11 after stall");
        check("s10_arch10", src1_tag[0], 10);
        check("s10_arch11", src2_tag[0], 11);
        tick(); idle();

        // An invalid lane 0 does not block lane 1, and lane 1 takes tag index 0.
        lane(1, 1, 1, 12, 0, 0);
        free_reg[0] = 6'd60; free_reg[1] = 6'd61; free_reg_valid = 2'b01;
        #1;
        $display("[TB] lane0 idle, lane1 dest=12");
        check("s11_accept", rn_accept, 2'b10);
        check("s11_dispatch", dispatch_en, 2'b01);
        check("s11_dest1", dest_tag[1], 60);
        tick(); idle();

        lane(0, 1, 0, 0, 12, 0);
        #1;
        check("s12_arch12", src1_tag[0], 60);

        // Reset in the middle of operation restores the identity map.
        reset_n = 1'b0;
        lane(0, 1, 1, 13, 5, 0);
        free_reg[0] = 6'd62; free_reg_valid = 2'b01;
        #1;
        $display("[TB] mid-run reset");
        check("s13_accept", rn_accept, 2'b00);
        check("s13_dispatch", dispatch_en, 2'b00);
        tick();
        reset_n = 1'b1;
        idle();
        lane(0, 1, 0, 0, 5, 12); lane(1, 1, 0, 0, 3, 13);
        #1;
        check("s14_arch5", src1_tag[0], 5);
        check("s14_arch12", src2_tag[0], 12);
        check("s14_arch3", src1_tag[1], 3);
        check("s14_arch13", src2_tag[1], 13);
        tick(); idle();

`ifdef RENAME_RECOVER_EN
        // Rename 4 -> 50, then flush while arch 4 retires with tag 45.
        lane(0, 1, 1, 4, 0, 0);
        free_reg[0] = 6'd50; free_reg_valid = 2'b01;
        #1;
        $display("[TB] recover: rename arch 4");
        check("r1_dest0", dest_tag[0], 50);
        tick(); idle();
        flush = 1'b1; ret_en = 2'b01; ret_arch[0] = 5'd4; ret_tag[0] = 6'd45;
        lane(0, 1, 1, 9, 4, 0);
        free_reg[0] = 6'd33; free_reg_valid = 2'b01;
        #1;
        $display("[TB] recover: flush with retire arch 4 -> 45");
        check("r2_accept", rn_accept, 2'b00);
        check("r2_dispatch", dispatch_en, 2'b00);
        tick(); idle();
        lane(0, 1, 0, 0, 4, 9);
        #1;
        check("r3_arch4", src1_tag[0], 45);
        check("r3_arch9", src2_tag[0], 9);
        tick(); idle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
